// File: rtl/mem_wb_stage.sv
// mem_wb_stage: memory / write-back stage with a word-organised synchronous data RAM.
// Executes the decoded control bundle from EX. ALU, store and bubble instructions
// retire one cycle after accept. Loads stall EX for one cycle and retire two cycles
// after accept.
// Optional feature macro DMEM_SUBWORD_EN: byte/halfword loads and stores with
// sign/zero extension and misalignment detection. Without it every access is a
// full word and mem_misalign is tied low.
module mem_wb_stage #(
    parameter int XLEN       = 32,
    parameter int DMEM_DEPTH = 1024
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ex_valid,
    output logic            ex_ready,
    input  logic [XLEN-1:0] ex_alu_data,
    input  logic [XLEN-1:0] ex_rs2_data,
    input  logic [4:0]      ex_rd,
    input  logic [2:0]      ex_funct3,
    input  logic            ex_reg_w_en,
    input  logic            ex_mem_w_en,
    input  logic            ex_mem_alu_sel,
    output logic            wb_valid,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            wb_reg_w_en,
    output logic            mem_misalign
);
    localparam int AW = $clog2(DMEM_DEPTH);
    localparam int NB = XLEN / 8;

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_LOAD = 1'b1;

    logic [0:0]      state;
    logic [XLEN-1:0] dmem [DMEM_DEPTH];

    logic            xfer;
    logic            is_store;
    logic            is_alu;
    logic            is_load;
    logic            acc_mis;
    logic [AW-1:0]   idx;
    logic [NB-1:0]   st_be;
    logic [XLEN-1:0] st_data;
    logic [XLEN-1:0] ld_result;

    logic [XLEN-1:0] rdata_p0;
    logic [4:0]      ld_rd_p0;
    logic            ld_mis_p0;

    assign ex_ready = (state == ST_RUN);
    assign xfer     = ex_valid & ex_ready;
    // a store wins over every other flag; the register write is then suppressed
    assign is_store = ex_mem_w_en;
    assign is_alu   = !ex_mem_w_en & ex_mem_alu_sel;
    assign is_load  = !ex_mem_w_en & !ex_mem_alu_sel & ex_reg_w_en;
    // word index; address bits above the RAM wrap modulo the depth
    assign idx      = ex_alu_data[AW+1:2];

`ifdef DMEM_SUBWORD_EN
    logic [2:0] ld_f3_p0;
    logic [1:0] ld_off_p0;

    // access size code: 0 byte, 1 halfword, 2 word (unknown funct3 -> word)
    function automatic logic [1:0] acc_size(input logic [2:0] f3, input logic load);
        if (f3 == 3'b000 || (load && f3 == 3'b100)) return 2'd0;
        if (f3 == 3'b001 || (load && f3 == 3'b101)) return 2'd1;
        return 2'd2;
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'd0:    return 1'b0;
            2'd1:    return off[0];
            default: return off != 2'b00;
        endcase
    endfunction

    // pick the addressed lanes out of the RAM word and extend to XLEN
    function automatic logic [XLEN-1:0] load_ext(input logic [XLEN-1:0] word,
                                                 input logic [2:0] f3,
                                                 input logic [1:0] off);
        logic [XLEN-1:0] sh;
        sh = word >> {off, 3'b000};
        case (acc_size(f3, 1'b1))
            2'd0:    return f3[2] ? {{(XLEN-8){1'b0}}, sh[7:0]}
                                  : {{(XLEN-8){sh[7]}}, sh[7:0]};
            2'd1:    return f3[2] ? {{(XLEN-16){1'b0}}, sh[15:0]}
                                  : {{(XLEN-16){sh[15]}}, sh[15:0]};
            default: return word;
        endcase
    endfunction

    // store byte enables and lane-aligned store data
    always_comb begin
        st_data = ex_rs2_data << {ex_alu_data[1:0], 3'b000};
        case (acc_size(ex_funct3, 1'b0))
            2'd0:    st_be = {{(NB-1){1'b0}}, 1'b1} << ex_alu_data[1:0];
            2'd1:    st_be = {{(NB-2){1'b0}}, 2'b11} << ex_alu_data[1:0];
            default: begin
                st_be   = '1;
                st_data = ex_rs2_data;
            end
        endcase
    end

    assign acc_mis   = misaligned(acc_size(ex_funct3, is_load), ex_alu_data[1:0]);
    assign ld_result = load_ext(rdata_p0, ld_f3_p0, ld_off_p0);

    // remember the load's size and lane offset for the extraction one cycle later
    always_ff @(posedge clk) begin
        if (xfer && is_load) begin
            ld_f3_p0  <= ex_funct3;
            ld_off_p0 <= ex_alu_data[1:0];
        end
    end
`else
    logic unused_bits;

    assign unused_bits = ^ex_funct3;
    assign st_be       = '1;
    assign st_data     = ex_rs2_data;
    assign acc_mis     = 1'b0;
    assign ld_result   = rdata_p0;
`endif

    // data RAM: lane write on an accepted store, registered read on an accepted load
    always_ff @(posedge clk) begin
        if (xfer && rst_n) begin
            if (is_store && !acc_mis) begin
                for (int b = 0; b < NB; b++) begin
                    if (st_be[b]) dmem[idx][8*b +: 8] <= st_data[8*b +: 8];
                end
            end
            if (is_load) begin
                rdata_p0  <= dmem[idx];
                ld_rd_p0  <= ex_rd;
                ld_mis_p0 <= acc_mis;
            end
        end
    end

    // RUN/LOAD sequencing and the write-back output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_RUN;
            wb_valid     <= 1'b0;
            wb_rd        <= '0;
            wb_data      <= '0;
            wb_reg_w_en  <= 1'b0;
            mem_misalign <= 1'b0;
        end else begin
            wb_valid     <= 1'b0;
            wb_reg_w_en  <= 1'b0;
            mem_misalign <= 1'b0;
            if (state == ST_LOAD) begin
                state        <= ST_RUN;
                wb_valid     <= 1'b1;
                wb_rd        <= ld_rd_p0;
                wb_data      <= ld_mis_p0 ? '0 : ld_result;
                wb_reg_w_en  <= !ld_mis_p0 && (ld_rd_p0 != 5'd0);
                mem_misalign <= ld_mis_p0;
            end else if (xfer) begin
                if (is_load) begin
                    state <= ST_LOAD;
                end else begin
                    wb_valid     <= 1'b1;
                    wb_rd        <= ex_rd;
                    wb_data      <= (is_store && acc_mis) ? '0 : ex_alu_data;
                    wb_reg_w_en  <= is_alu && ex_reg_w_en && (ex_rd != 5'd0);
                    mem_misalign <= is_store && acc_mis;
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed and randomized bench for mem_wb_stage against a
// byte-addressed reference memory and a queue of expected retirements.
module tb_mem_wb_stage;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_alu_data;
    logic [31:0] ex_rs2_data;
    logic [4:0]  ex_rd;
    logic [2:0]  ex_funct3;
    logic        ex_reg_w_en;
    logic        ex_mem_w_en;
    logic        ex_mem_alu_sel;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_reg_w_en;
    logic        mem_misalign;

    always #5 clk = ~clk;

    mem_wb_stage dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_alu_data(ex_alu_data), .ex_rs2_data(ex_rs2_data), .ex_rd(ex_rd),
        .ex_funct3(ex_funct3), .ex_reg_w_en(ex_reg_w_en), .ex_mem_w_en(ex_mem_w_en),
        .ex_mem_alu_sel(ex_mem_alu_sel), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .wb_data(wb_data), .wb_reg_w_en(wb_reg_w_en), .mem_misalign(mem_misalign)
    );

    typedef struct {
        int          due;
        logic [4:0]  rd;
        logic [31:0] data;
        bit          chk_data;
        logic        wen;
        logic        mis;
    } exp_t;

    exp_t        expq[$];
    exp_t        ce;
    logic [7:0]  bm [int];
    int          edge_cnt   = 0;
    int          stall_edge = -1;
    int          total      = 0;
    int          bad        = 0;
    bit          chk_en     = 0;
    logic [4:0]  last_rd    = 5'd0;
    logic [31:0] last_data  = 32'd0;
    bit          last_known = 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rd_bytes(input int a, input int n);
        logic [31:0] v;
        v = 32'd0;
        for (int i = n - 1; i >= 0; i--) v = (v << 8) | {24'd0, bm[(a + i) % 4096]};
        return v;
    endfunction

    // Reference: byte-addressed memory of DEPTH*4 bytes, little-endian.
    function automatic void model_accept(input logic [31:0] alu, input logic [31:0] rs2,
                                         input logic [4:0] rd, input logic [2:0] f3,
                                         input logic rw, input logic mw, input logic sel,
                                         output exp_t e, output bit ld);
        int          a;
        int          n;
        bit          uns;
        bit          mis;
        logic [31:0] v;
        a   = int'(alu & 32'hFFF);
        n   = 4;
        uns = 0;
        mis = 0;
`ifdef DMEM_SUBWORD_EN
        if (f3 == 3'd0 || (!mw && f3 == 3'd4)) n = 1;
        else if (f3 == 3'd1 || (!mw && f3 == 3'd5)) n = 2;
        uns = !mw && f3[2];
        mis = (a % n) != 0;
`else
        a = a & ~3;
`endif
        e.due = 0; e.rd = rd; e.data = 32'd0; e.chk_data = 1; e.wen = 1'b0; e.mis = 1'b0;
        ld = 0;
        if (mw) begin
            e.mis = mis;
            e.chk_data = mis;
            if (!mis) for (int i = 0; i < n; i++) bm[(a + i) % 4096] = rs2[8*i +: 8];
        end else if (sel) begin
            e.data = alu;
            e.wen  = rw && (rd != 5'd0);
        end else if (rw) begin
            ld = 1;
            e.mis = mis;
            if (!mis) begin
                v = rd_bytes(a, n);
                if (n == 1 && !uns) v = {{24{v[7]}}, v[7:0]};
                if (n == 2 && !uns) v = {{16{v[15]}}, v[15:0]};
                e.data = v;
                e.wen  = (rd != 5'd0);
            end
        end else begin
            e.chk_data = 0;
        end
    endfunction

    task automatic issue(input logic [31:0] alu, input logic [31:0] rs2, input logic [4:0] rd,
                         input logic [2:0] f3, input logic rw, input logic mw, input logic sel);
        exp_t e;
        bit   ld;
        @(negedge clk);
        while (edge_cnt + 1 == stall_edge) begin
            ex_valid = 1'b0;
            @(negedge clk);
        end
        ex_valid = 1'b1; ex_alu_data = alu; ex_rs2_data = rs2; ex_rd = rd; ex_funct3 = f3;
        ex_reg_w_en = rw; ex_mem_w_en = mw; ex_mem_alu_sel = sel;
        model_accept(alu, rs2, rd, f3, rw, mw, sel, e, ld);
        e.due = edge_cnt + 1 + (ld ? 1 : 0);
        if (ld) stall_edge = edge_cnt + 2;
        expq.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            ex_valid = 1'b0;
        end
    endtask

    // per-cycle compare of DUT outputs against the expected retirement queue
    always @(posedge clk) begin
        edge_cnt++;
        #2;
        if (chk_en) begin
            if (expq.size() > 0 && expq[0].due == edge_cnt) begin
                ce = expq.pop_front();
                chk("wb_valid", wb_valid, 1);
                chk("wb_rd", wb_rd, ce.rd);
                chk("wb_reg_w_en", wb_reg_w_en, ce.wen);
                chk("mem_misalign", mem_misalign, ce.mis);
                if (ce.chk_data) chk("wb_data", wb_data, ce.data);
                last_rd = ce.rd;
                last_data = ce.data;
                last_known = ce.chk_data;
            end else begin
                chk("idle_wb_valid", wb_valid, 0);
                chk("idle_wb_reg_w_en", wb_reg_w_en, 0);
                chk("idle_mem_misalign", mem_misalign, 0);
                chk("hold_wb_rd", wb_rd, last_rd);
                if (last_known) chk("hold_wb_data", wb_data, last_data);
            end
            chk("ex_ready", ex_ready, (edge_cnt + 1 == stall_edge) ? 0 : 1);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] f3_tab [6];
        f3_tab = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
        rst_n = 1'b0; ex_valid = 1'b0; ex_alu_data = '0; ex_rs2_data = '0; ex_rd = '0;
        ex_funct3 = '0; ex_reg_w_en = 1'b0; ex_mem_w_en = 1'b0; ex_mem_alu_sel = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_wb_rd", wb_rd, 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_wb_reg_w_en", wb_reg_w_en, 0);
        chk("rst_mem_misalign", mem_misalign, 0);
        rst_n = 1'b1;
        chk_en = 1;

        // ALU retire, latency 1
        issue(32'h00001234, 32'h0, 5'd5, 3'd0, 1'b1, 1'b0, 1'b1);
        idle(1);
        chk("alu_valid", wb_valid, 1);
        chk("alu_rd", wb_rd, 5);
        chk("alu_data", wb_data, 32'h00001234);
        chk("alu_wen", wb_reg_w_en, 1);

        // store then load of the same word, one stall cycle
        issue(32'h10, 32'hDEADBEEF, 5'd0, 3'd2, 1'b0, 1'b1, 1'b0);
        issue(32'h10, 32'h0, 5'd7, 3'd2, 1'b1, 1'b0, 1'b0);
        idle(1);
        chk("lw_stall_ready", ex_ready, 0);
        chk("lw_stall_valid", wb_valid, 0);
        idle(1);
        chk("lw_valid", wb_valid, 1);
        chk("lw_rd", wb_rd, 7);
        chk("lw_data", wb_data, 32'hDEADBEEF);
        chk("lw_wen", wb_reg_w_en, 1);

        // address wrap modulo depth
        issue(32'h1000, 32'hCAFEF00D, 5'd0, 3'd2, 1'b0, 1'b1, 1'b0);
        issue(32'h0, 32'h0, 5'd8, 3'd2, 1'b1, 1'b0, 1'b0);
        idle(2);
        chk("wrap_data", wb_data, 32'hCAFEF00D);

        // rd=0, bubble, store with reg_w_en
        issue(32'h77, 32'h0, 5'd0, 3'd0, 1'b1, 1'b0, 1'b1);
        idle(1);
        chk("rd0_valid", wb_valid, 1);
        chk("rd0_wen", wb_reg_w_en, 0);
        issue(32'h10, 32'h5555AAAA, 5'd9, 3'd2, 1'b0, 1'b0, 1'b0);
        idle(1);
        chk("bubble_valid", wb_valid, 1);
        chk("bubble_wen", wb_reg_w_en, 0);
        issue(32'h10, 32'h0, 5'd4, 3'd2, 1'b1, 1'b0, 1'b0);
        idle(2);
        chk("bubble_ram_kept", wb_data, 32'hDEADBEEF);
        issue(32'h14, 32'h0BADF00D, 5'd6, 3'd2, 1'b1, 1'b1, 1'b0);
        idle(1);
        chk("st_rw_valid", wb_valid, 1);
        chk("st_rw_wen", wb_reg_w_en, 0);

`ifdef DMEM_SUBWORD_EN
        issue(32'h10, 32'h11223344, 5'd0, 3'd2, 1'b0, 1'b1, 1'b0);
        issue(32'h13, 32'h123456AB, 5'd0, 3'd0, 1'b0, 1'b1, 1'b0);
        issue(32'h13, 32'h0, 5'd1, 3'd0, 1'b1, 1'b0, 1'b0);
        idle(2);
        chk("lb_data", wb_data, 32'hFFFFFFAB);
        issue(32'h13, 32'h0, 5'd2, 3'd4, 1'b1, 1'b0, 1'b0);
        idle(2);
        chk("lbu_data", wb_data, 32'h000000AB);
        issue(32'h11, 32'h0000BEEF, 5'd0, 3'd1, 1'b0, 1'b1, 1'b0);
        idle(1);
        chk("sh_mis_flag", mem_misalign, 1);
        chk("sh_mis_valid", wb_valid, 1);
        chk("sh_mis_data", wb_data, 0);
        issue(32'h10, 32'h0, 5'd3, 3'd2, 1'b1, 1'b0, 1'b0);
        idle(2);
        chk("sub_lw_data", wb_data, 32'hAB223344);
`endif

        // reset asserted in the LOAD cycle drops the load
        issue(32'h55, 32'h0, 5'd3, 3'd0, 1'b1, 1'b0, 1'b1);
        issue(32'h10, 32'h0, 5'd6, 3'd2, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        ex_valid = 1'b0;
        chk("pre_rst_ready", ex_ready, 0);
        chk("pre_rst_wb_rd", wb_rd, 3);
        chk_en = 0;
        rst_n = 1'b0;
        #1;
        chk("arst_wb_valid", wb_valid, 0);
        chk("arst_wb_rd", wb_rd, 0);
        chk("arst_wb_data", wb_data, 0);
        chk("arst_wb_reg_w_en", wb_reg_w_en, 0);
        chk("arst_mem_misalign", mem_misalign, 0);
        repeat (2) begin
            @(negedge clk);
            chk("arst_no_pulse", wb_valid, 0);
        end
        rst_n = 1'b1;
        #1;
        chk("arst_release_ready", ex_ready, 1);
        expq.delete();
        stall_edge = -1;
        last_rd = 5'd0;
        last_data = 32'd0;
        last_known = 1;
        chk_en = 1;

        // initialise the random address pool 0x100..0x11F
        for (int w = 0; w < 8; w++) issue(32'h100 + 32'(4 * w), $urandom, 5'd0, 3'd2, 1'b0, 1'b1, 1'b0);

        for (int n = 0; n < 1500; n++) begin
            logic [31:0] a;
            logic [31:0] r;
            logic [4:0]  rd;
            logic [2:0]  f3;
            int          k;
            k  = $urandom_range(0, 9);
            a  = 32'h100 + 32'($urandom_range(0, 31)) + (32'($urandom_range(0, 3)) << 12);
            r  = $urandom;
            rd = 5'($urandom_range(0, 31));
            f3 = f3_tab[$urandom_range(0, 5)];
            if (k <= 2) issue($urandom, r, rd, f3, 1'($urandom_range(0, 1)), 1'b0, 1'b1);
            else if (k <= 5) issue(a, r, rd, f3, 1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1)));
            else if (k <= 8) issue(a, r, rd, f3, 1'b1, 1'b0, 1'b0);
            else issue(a, r, rd, f3, 1'b0, 1'b0, 1'b0);
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
        end
        idle(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
